sobel_grid_edge: RTL and testbench
==================================

// Module: sobel_grid_edge
// PURPOSE
//  - Downstream consumer of the 3x3 line-buffer window: takes the 270-bit grid plus the aligned centre pixel.
//  - Computes a Sobel gradient magnitude on luma and flags edges against a runtime threshold.
//  - Emits the cartoonifier output pixel: black on edge, centre pixel otherwise.
//  - 3-stage pipeline, advancing only on clken, so it runs in lockstep with the line buffer.
// PARAMETERS
//  - WIDTH   800  active pixels per row (640 when VGA_640x480p60 is defined)
//  - HEIGHT  600  active rows per frame (480 when VGA_640x480p60 is defined)
// PORTS
//  - clock       in   1    pixel clock
//  - reset       in   1    synchronous, active-high
//  - clken       in   1    advance strobe; same strobe as the line buffer
//  - iSof        in   1    qualified by clken; the current iCenter is frame pixel (0,0)
//  - iGrid       in   270  window, grid[k] = iGrid[30k+29:30k]; row 2 = grid[8:6] (newest), row 0 = grid[2:0]
//  - iCenter     in   30   grid[4] pixel, {R[29:20],G[19:10],B[9:0]}
//  - iThreshold  in   13   unsigned edge threshold, sampled in stage 3
//  - oPixel      out  30   output pixel (registered)
//  - oEdge       out  1    edge flag for oPixel
//  - oValid      out  1    pipeline primed; oPixel is meaningful
// BEHAVIOUR
//  - Reset: all pipeline registers, oPixel=0, oEdge=0, oValid=0, x=0, y=0.
//    Reset overrides clken and applies mid-frame with no residue.
//  - clken=0: every register holds, including counters and the valid shifter.
//  - Latency: inputs accepted on clken beat n appear on outputs after beat n+2 (3 clken beats).
//    Unqualified clock cycles do not count.
//  - S1 (luma): per tap L[k] = (R + 2G + B) >> 2. Sum is 12 bits, result is 10 bits unsigned.
//    Register all 9 L values, the centre pixel, and the border flag.
//  - S2 (gradient), 13-bit signed:
//    Gx = (L2 + 2L5 + L8) - (L0 + 2L3 + L6)
//    Gy = (L0 + 2L1 + L2) - (L6 + 2L7 + L8)
//    Range is +/-4092, so no overflow.
//  - S3 (decision): mag = |Gx| + |Gy|, 13 bits unsigned (max 8184, no saturation needed).
//    edge = (mag >= iThreshold) && !border.
//    oPixel = edge ? 30'd0 : delayed centre. oEdge = edge.
//  - Position counters (x, y) track the centre pixel, stepping on clken:
//    - iSof with clken loads x=1, y=0, and the current beat is treated as (0,0).
//    - Otherwise x increments. When x==WIDTH-1 it wraps to 0 and y increments; y wraps HEIGHT-1 -> 0.
//    - iSof with a simultaneous wrap: iSof wins.
//    - border = (x==0)|(x==WIDTH-1)|(y==0)|(y==HEIGHT-1), using the position of the beat being accepted.
//  - Border pixels pass the centre unmodified with oEdge=0, since their window wraps across rows/frames.
//  - oValid: 3-bit shifter fed 1 on each clken. oValid=shifter[2], cleared only by reset.
//    Before oValid=1, oPixel/oEdge stay at reset values.
// STRUCTURE
//  - Shared package: PIX_W=30, CH_W=10, GRID_N=9, LUMA_W=10, GRAD_W=13.
//    Also channel slice localparams and grid index constants (GRID_TL=8 .. GRID_BR=0).
//  - One sub-module, rgb_to_luma (combinational, 30->10).
//    Instantiated 9x in S1; everything else stays inline.
// TESTING
//  - Flat grid, all taps 30'h3FF_3FF_3FF, interior position, threshold 100, clken=1:
//    after 3 beats oValid=1, oEdge=0, oPixel=iCenter.
//  - Vertical edge: grid[2,5,8]=white (luma 1023), others 0, interior position, threshold 100:
//    Gx=4092, Gy=0, mag=4092, so oEdge=1 and oPixel=0.
//    Repeat with threshold 4093: oEdge=0 and oPixel=iCenter.
//  - Border: same vertical-edge window with iSof on that beat, i.e. (0,0):
//    oEdge=0. The beat with x=WIDTH-1 also gives oEdge=0.
//    Check y wraps to 0 after WIDTH*HEIGHT beats without iSof.
//  - clken gaps: alternate clken 1/0 with distinct patterns.
//    Outputs change only after qualified beats, latency stays 3 beats, and held values are stable.
//  - Reset mid-stream, after 10 primed beats: next cycle oValid=0, oPixel=0, oEdge=0.
//    Re-priming takes 3 clken beats. Counters restart at (0,0).

Source files
------------

// File: rtl/sobel_grid_edge_pkg.sv
// Shared widths, channel slices, grid tap indices and small arithmetic helpers
// for the Sobel edge stage of the cartoonifier.
package sobel_grid_edge_pkg;

  localparam int PIX_W  = 30;
  localparam int CH_W   = 10;
  localparam int GRID_N = 9;
  localparam int LUMA_W = 10;
  localparam int GRAD_W = 13;
  localparam int MAG_W  = 13;
  localparam int THR_W  = 13;
  localparam int GRID_W = PIX_W * GRID_N;

  localparam int R_LSB = 20;
  localparam int G_LSB = 10;
  localparam int B_LSB = 0;

  localparam int GRID_TL = 8;
  localparam int GRID_TC = 7;
  localparam int GRID_TR = 6;
  localparam int GRID_ML = 5;
  localparam int GRID_MC = 4;
  localparam int GRID_MR = 3;
  localparam int GRID_BL = 2;
  localparam int GRID_BC = 1;
  localparam int GRID_BR = 0;

`ifdef VGA_640x480p60
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
`else
  localparam int DEF_WIDTH  = 800;
  localparam int DEF_HEIGHT = 600;
`endif

  typedef logic [LUMA_W-1:0]        luma_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [MAG_W-1:0]         mag_t;

  // One Sobel kernel row/column: a + 2b + c, always non-negative and below 4096.
  function automatic grad_t tri_sum(input luma_t a, input luma_t b, input luma_t c);
    return grad_t'({2'b00, a}) + grad_t'({1'b0, b, 1'b0}) + grad_t'({2'b00, c});
  endfunction

  function automatic mag_t abs_grad(input grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

endpackage

// File: rtl/rgb_to_luma.sv
// Cheap luma approximation (R + 2G + B) / 4 for one 30-bit RGB pixel.
module rgb_to_luma
  import sobel_grid_edge_pkg::*;
(
  input  logic [PIX_W-1:0]  pixel,
  output logic [LUMA_W-1:0] luma
);

  localparam int SUM_W = LUMA_W + 2;

  logic [SUM_W-1:0] sum;

  assign sum  = SUM_W'(pixel[R_LSB +: CH_W])
              + {1'b0, pixel[G_LSB +: CH_W], 1'b0}
              + SUM_W'(pixel[B_LSB +: CH_W]);
  assign luma = LUMA_W'(sum >> 2);

endmodule

// File: rtl/sobel_grid_edge.sv
// Three-stage Sobel edge detector on the 3x3 window: luma, gradient, threshold.
// Edge pixels go black, everything else passes the centre pixel through.
module sobel_grid_edge
  import sobel_grid_edge_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clken,
  input  logic              iSof,
  input  logic [GRID_W-1:0] iGrid,
  input  logic [PIX_W-1:0]  iCenter,
  input  logic [THR_W-1:0]  iThreshold,
  output logic [PIX_W-1:0]  oPixel,
  output logic              oEdge,
  output logic              oValid
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q, cur_x;
  logic [YW-1:0] y_q, cur_y;
  logic          border;

  luma_t         luma_c  [GRID_N];
  luma_t         luma_s1 [GRID_N];
  logic [PIX_W-1:0] center_s1, center_s2;
  logic          border_s1, border_s2;

  grad_t         gx_c, gy_c, gx_s2, gy_s2;
  mag_t          mag_c;
  logic          is_edge;
  logic [2:0]    valid_sr;

  // A start-of-frame beat is itself pixel (0,0), regardless of the running count.
  always_comb begin
    cur_x  = iSof ? '0 : x_q;
    cur_y  = iSof ? '0 : y_q;
    border = (cur_x == '0) || (cur_x == X_LAST) || (cur_y == '0) || (cur_y == Y_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clken) begin
      if (iSof) begin
        x_q <= XW'(1);
        y_q <= '0;
      end else if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < GRID_N; k++) begin : g_luma
    rgb_to_luma u_luma (
      .pixel (iGrid[k*PIX_W +: PIX_W]),
      .luma  (luma_c[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < GRID_N; k++) luma_s1[k] <= '0;
      center_s1 <= '0;
      border_s1 <= 1'b0;
    end else if (clken) begin
      for (int k = 0; k < GRID_N; k++) luma_s1[k] <= luma_c[k];
      center_s1 <= iCenter;
      border_s1 <= border;
    end
  end

  assign gx_c = tri_sum(luma_s1[GRID_BL], luma_s1[GRID_ML], luma_s1[GRID_TL])
              - tri_sum(luma_s1[GRID_BR], luma_s1[GRID_MR], luma_s1[GRID_TR]);
  assign gy_c = tri_sum(luma_s1[GRID_BR], luma_s1[GRID_BC], luma_s1[GRID_BL])
              - tri_sum(luma_s1[GRID_TR], luma_s1[GRID_TC], luma_s1[GRID_TL]);

  always_ff @(posedge clock) begin
    if (reset) begin
      gx_s2     <= '0;
      gy_s2     <= '0;
      center_s2 <= '0;
      border_s2 <= 1'b0;
    end else if (clken) begin
      gx_s2     <= gx_c;
      gy_s2     <= gy_c;
      center_s2 <= center_s1;
      border_s2 <= border_s1;
    end
  end

  assign mag_c   = abs_grad(gx_s2) + abs_grad(gy_s2);
  assign is_edge = (mag_c >= iThreshold) && !border_s2;

  // Outputs only load once real data reaches stage 3, so they sit at zero while priming.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_sr <= '0;
      oPixel   <= '0;
      oEdge    <= 1'b0;
    end else if (clken) begin
      valid_sr <= {valid_sr[1:0], 1'b1};
      if (valid_sr[1]) begin
        oPixel <= is_edge ? '0 : center_s2;
        oEdge  <= is_edge;
      end
    end
  end

  assign oValid = valid_sr[2];

endmodule

// File: tb/tb_sobel_grid_edge.sv
// Scoreboard bench for sobel_grid_edge on a small 8x6 frame: directed windows
// with hand-derived gradient magnitudes, clken gaps, thresholds and resets.
module tb_sobel_grid_edge;
  import sobel_grid_edge_pkg::*;

  localparam int W = 8;
  localparam int H = 6;
  localparam logic [PIX_W-1:0] WHITE = 30'h3FFF_FFFF;

  logic              clock = 1'b0;
  logic              reset;
  logic              clken;
  logic              iSof;
  logic [GRID_W-1:0] iGrid;
  logic [PIX_W-1:0]  iCenter;
  logic [THR_W-1:0]  iThreshold;
  logic [PIX_W-1:0]  oPixel;
  logic              oEdge;
  logic              oValid;

  int checks   = 0;
  int failures = 0;
  int px = 0;
  int py = 0;
  logic [PIX_W:0] sb [$];

  // White-tap masks and their hand-computed |Gx|+|Gy| (white luma = 1023).
  logic [8:0] masks [7] = '{9'h000, 9'h1FF, 9'h124, 9'h049, 9'h007, 9'h004, 9'h1C0};
  int         mags  [7] = '{0, 0, 4092, 4092, 4092, 2046, 4092};

  sobel_grid_edge #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock      (clock),
    .reset      (reset),
    .clken      (clken),
    .iSof       (iSof),
    .iGrid      (iGrid),
    .iCenter    (iCenter),
    .iThreshold (iThreshold),
    .oPixel     (oPixel),
    .oEdge      (oEdge),
    .oValid     (oValid)
  );

  always #5 clock = ~clock;

  function automatic logic [GRID_W-1:0] make_grid(input logic [8:0] m);
    logic [GRID_W-1:0] g;
    g = '0;
    for (int k = 0; k < GRID_N; k++) g[k*PIX_W +: PIX_W] = m[k] ? WHITE : '0;
    return g;
  endfunction

  function automatic logic [PIX_W-1:0] center_of(input int b);
    return PIX_W'(32'(b) * 32'h0010_0401 + 32'h0000_0005);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // One qualified beat; the expected result is queued using the bench's own position.
  task automatic apply_stimulus(input int p, input logic sof, input logic [PIX_W-1:0] center);
    logic interior;
    logic hit;
    @(negedge clock);
    if (sof) begin
      px = 0;
      py = 0;
    end
    interior   = (px != 0) && (px != W-1) && (py != 0) && (py != H-1);
    hit        = interior && (mags[p] >= int'(iThreshold));
    reset      = 1'b0;
    clken      = 1'b1;
    iSof       = sof;
    iGrid      = make_grid(masks[p]);
    iCenter    = center;
    sb.push_back({hit, hit ? '0 : center});
    px++;
    if (px == W) begin
      px = 0;
      py = (py == H-1) ? 0 : py + 1;
    end
  endtask

  task automatic apply_gap(input int seed);
    @(negedge clock);
    clken   = 1'b0;
    iSof    = 1'b1;
    iGrid   = make_grid(masks[seed % 7] ^ 9'h0A5);
    iCenter = 30'h2AAA_AAAA ^ PIX_W'(seed);
  endtask

  task automatic do_reset(input logic [THR_W-1:0] thr);
    @(negedge clock);
    reset      = 1'b1;
    clken      = 1'b1;
    iSof       = 1'b0;
    iGrid      = make_grid(9'h124);
    iCenter    = 30'h0123_4567;
    iThreshold = thr;
    sb.delete();
    px = 0;
    py = 0;
    @(negedge clock);
    reset = 1'b0;
    clken = 1'b0;
    check_output("rst_valid", oValid, 0);
    check_output("rst_pixel", oPixel, 0);
    check_output("rst_edge", oEdge, 0);
  endtask

  task automatic idle_check(input string name);
    @(negedge clock);
    clken = 1'b0;
    iSof  = 1'b0;
    check_output(name, sb.size(), 2);
  endtask

  // Monitor: pops on every primed qualified beat, checks hold on all other cycles.
  initial begin
    int nbeats;
    logic rst_s, beat_s;
    logic [PIX_W-1:0] last_pixel;
    logic last_edge;
    logic [PIX_W:0] exp_item;
    nbeats     = 0;
    last_pixel = '0;
    last_edge  = 1'b0;
    forever begin
      @(posedge clock);
      rst_s  = reset;
      beat_s = clken && !reset;
      #1;
      if (rst_s) begin
        nbeats     = 0;
        last_pixel = '0;
        last_edge  = 1'b0;
      end else if (beat_s) begin
        nbeats++;
        if (nbeats >= 3) begin
          check_output("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            exp_item   = sb.pop_front();
            last_pixel = exp_item[PIX_W-1:0];
            last_edge  = exp_item[PIX_W];
          end
        end
        check_output("beat_valid", oValid, nbeats >= 3);
        check_output("beat_pixel", oPixel, last_pixel);
        check_output("beat_edge", oEdge, last_edge);
      end else begin
        check_output("hold_valid", oValid, nbeats >= 3);
        check_output("hold_pixel", oPixel, last_pixel);
        check_output("hold_edge", oEdge, last_edge);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset      = 1'b1;
    clken      = 1'b0;
    iSof       = 1'b0;
    iGrid      = '0;
    iCenter    = '0;
    iThreshold = 13'd100;
    repeat (2) @(negedge clock);

    // Two full frames, only the first starts with iSof; border pattern must repeat.
    do_reset(13'd100);
    for (int b = 0; b < 2*W*H; b++) apply_stimulus(b % 7, b == 0, center_of(b));
    idle_check("a_inflight");

    // Threshold just above the strongest possible gradient of these windows.
    do_reset(13'd4093);
    for (int b = 0; b < 16; b++) apply_stimulus((b % 2) ? 2 : 4, b == 0, center_of(b + 200));
    idle_check("b_inflight");

    // Single white tap gives mag 2046: equal threshold fires, one above does not.
    do_reset(13'd2046);
    for (int b = 0; b < 16; b++) apply_stimulus(5, b == 0, center_of(b + 300));
    idle_check("c_inflight");
    do_reset(13'd2047);
    for (int b = 0; b < 16; b++) apply_stimulus(5, b == 0, center_of(b + 400));
    idle_check("c2_inflight");

    // clken gaps, with iSof and data toggling while unqualified.
    do_reset(13'd100);
    for (int b = 0; b < 24; b++) begin
      apply_stimulus(b % 7, b == 0, center_of(b + 500));
      apply_gap(b);
      if (b % 3 == 0) apply_gap(b + 1);
    end
    idle_check("d_inflight");

    // Mid-stream reset, then restart without iSof: counters must resume at (0,0).
    do_reset(13'd100);
    for (int b = 0; b < 12; b++) apply_stimulus(2, b == 0, center_of(b + 600));
    do_reset(13'd100);
    for (int b = 0; b < 12; b++) apply_stimulus(2, 1'b0, center_of(b + 700));
    idle_check("e_inflight");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
